// File: rtl/id_stage_reg.sv
// ID->EX pipeline register: captures decoded operands/control, turns condition-failed
// instructions into control-dead slots, and handles freeze, flush and hazard bubbles.
module id_stage_reg #(
    parameter int DATA_LEN     = 32,
    parameter int REG_ADDR_LEN = 4,
    parameter int EXE_CMD_LEN  = 4,
    parameter int KILL_CNT_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    freeze,
    input  logic                    hazard,
    input  logic                    condition_state,
    input  logic [DATA_LEN-1:0]     pc_in,
    input  logic [DATA_LEN-1:0]     val_rn_in,
    input  logic [DATA_LEN-1:0]     val_rm_in,
    input  logic                    imm_in,
    input  logic [11:0]             shift_operand_in,
    input  logic [23:0]             signed_imm_24_in,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    input  logic [REG_ADDR_LEN-1:0] src1_in,
    input  logic [REG_ADDR_LEN-1:0] src2_in,
    input  logic [EXE_CMD_LEN-1:0]  exe_cmd_in,
    input  logic                    wb_en_in,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic                    b_in,
    input  logic                    s_in,
    input  logic [3:0]              status_in,
    output logic [DATA_LEN-1:0]     pc_out,
    output logic [DATA_LEN-1:0]     val_rn_out,
    output logic [DATA_LEN-1:0]     val_rm_out,
    output logic                    imm_out,
    output logic [11:0]             shift_operand_out,
    output logic [23:0]             signed_imm_24_out,
    output logic [REG_ADDR_LEN-1:0] dest_out,
    output logic [REG_ADDR_LEN-1:0] src1_out,
    output logic [REG_ADDR_LEN-1:0] src2_out,
    output logic [EXE_CMD_LEN-1:0]  exe_cmd_out,
    output logic                    wb_en_out,
    output logic                    mem_r_en_out,
    output logic                    mem_w_en_out,
    output logic                    b_out,
    output logic                    s_out,
    output logic [3:0]              status_out,
    output logic                    valid_out,
    output logic [KILL_CNT_LEN-1:0] kill_count
);

    localparam logic [KILL_CNT_LEN-1:0] KILL_ONE = 1;

    logic bubble;
    logic load;
    assign bubble = flush | hazard;
    assign load   = ~freeze & ~bubble;

    always_ff @(posedge clk) begin
        if (rst || (!freeze && bubble)) begin
            pc_out            <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            imm_out           <= 1'b0;
            shift_operand_out <= '0;
            signed_imm_24_out <= '0;
            dest_out          <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            exe_cmd_out       <= '0;
            wb_en_out         <= 1'b0;
            mem_r_en_out      <= 1'b0;
            mem_w_en_out      <= 1'b0;
            b_out             <= 1'b0;
            s_out             <= 1'b0;
            status_out        <= '0;
            valid_out         <= 1'b0;
        end else if (load) begin
            pc_out            <= pc_in;
            val_rn_out        <= val_rn_in;
            val_rm_out        <= val_rm_in;
            imm_out           <= imm_in;
            shift_operand_out <= shift_operand_in;
            signed_imm_24_out <= signed_imm_24_in;
            dest_out          <= dest_in;
            src1_out          <= src1_in;
            src2_out          <= src2_in;
            // exe_cmd passes through on a kill; s_out=0 keeps it from touching flags
            exe_cmd_out       <= exe_cmd_in;
            wb_en_out         <= wb_en_in & condition_state;
            mem_r_en_out      <= mem_r_en_in & condition_state;
            mem_w_en_out      <= mem_w_en_in & condition_state;
            b_out             <= b_in & condition_state;
            s_out             <= s_in & condition_state;
            status_out        <= status_in;
            valid_out         <= condition_state;
        end
    end

    // Debug counter of condition-killed slots; saturates rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            kill_count <= '0;
        end else if (load && !condition_state && kill_count != '1) begin
            kill_count <= kill_count + KILL_ONE;
        end
    end

endmodule

// File: tb/tb_id_stage_reg.sv
// Scoreboard bench for id_stage_reg: the driver pushes hand-derived expectations,
// a negedge monitor pops and compares one per clock.
module tb_id_stage_reg;

    typedef struct packed {
        logic [31:0] pc, rn, rm;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] si;
        logic [3:0]  dest, src1, src2, cmd;
        logic        wb, mr, mw, b, s;
        logic [3:0]  status;
    } in_t;

    typedef struct packed {
        in_t        f;
        logic       valid;
        logic [3:0] kc;
    } out_t;

    logic clk = 1'b0;
    logic rst, flush, freeze, hazard, condition_state;
    in_t  vin;
    out_t act;

    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic        imm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [3:0]  dest_out, src1_out, src2_out, exe_cmd_out, status_out, kill_count;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, valid_out;

    always #5 clk = ~clk;

    id_stage_reg #(
        .DATA_LEN(32), .REG_ADDR_LEN(4), .EXE_CMD_LEN(4), .KILL_CNT_LEN(4)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .hazard(hazard),
        .condition_state(condition_state),
        .pc_in(vin.pc), .val_rn_in(vin.rn), .val_rm_in(vin.rm), .imm_in(vin.imm),
        .shift_operand_in(vin.sh), .signed_imm_24_in(vin.si),
        .dest_in(vin.dest), .src1_in(vin.src1), .src2_in(vin.src2), .exe_cmd_in(vin.cmd),
        .wb_en_in(vin.wb), .mem_r_en_in(vin.mr), .mem_w_en_in(vin.mw),
        .b_in(vin.b), .s_in(vin.s), .status_in(vin.status),
        .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
        .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
        .exe_cmd_out(exe_cmd_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out),
        .status_out(status_out), .valid_out(valid_out), .kill_count(kill_count)
    );

    assign act = {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                  signed_imm_24_out, dest_out, src1_out, src2_out, exe_cmd_out,
                  wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, status_out,
                  valid_out, kill_count};

    out_t  exp_q[$];
    string name_q[$];
    out_t  cur;
    int    checks = 0;
    int    passes = 0;

    function automatic in_t mk(input logic [31:0] pc, input logic [4:0] ctl);
        in_t v;
        v.pc     = pc;
        v.rn     = pc ^ 32'hA5A5_0000;
        v.rm     = ~pc;
        v.imm    = pc[4];
        v.sh     = pc[11:0] ^ 12'h5A5;
        v.si     = pc[23:0] + 24'h000123;
        v.dest   = pc[7:4];
        v.src1   = pc[7:4] + 4'd1;
        v.src2   = pc[7:4] + 4'd2;
        v.cmd    = pc[7:4] ^ 4'h9;
        {v.wb, v.mr, v.mw, v.b, v.s} = ctl;
        v.status = pc[7:4] ^ 4'h6;
        return v;
    endfunction

    function automatic out_t ld(input in_t v, input logic [3:0] kc);
        out_t o;
        o.f = v; o.valid = 1'b1; o.kc = kc;
        return o;
    endfunction

    function automatic out_t kl(input in_t v, input logic [3:0] kc);
        out_t o;
        o.f = v; o.valid = 1'b0; o.kc = kc;
        {o.f.wb, o.f.mr, o.f.mw, o.f.b, o.f.s} = 5'b0;
        return o;
    endfunction

    function automatic out_t bub(input logic [3:0] kc);
        out_t o;
        o = '0; o.kc = kc;
        return o;
    endfunction

    task automatic step(input out_t e, input string nm);
        @(posedge clk);
        exp_q.push_back(e);
        name_q.push_back(nm);
        cur = e;
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act === e) passes++;
            else $display("FAIL %s: got %h expected %h", nm, act, e);
        end
    end

    in_t a, b, c, d, e, f;

    initial begin
        // reset with every input driven high
        rst = 1; vin = '1; freeze = 1; flush = 1; hazard = 1; condition_state = 1;
        step(bub(0), "reset_1");
        step(bub(0), "reset_2");
        rst = 0;
        step(bub(0), "reset_then_freeze");

        // pass then kill of the same instruction
        freeze = 0; flush = 0; hazard = 0;
        a = mk(32'h10, 5'b10001); vin = a; condition_state = 1;
        step(ld(a, 0), "pass_load");
        condition_state = 0;
        step(kl(a, 1), "kill_load");

        // freeze dominates flush/hazard and holds the counter
        b = mk(32'h20, 5'b11111); vin = b; condition_state = 1; freeze = 1; flush = 1;
        step(cur, "freeze_over_flush");
        condition_state = 0; hazard = 1;
        step(cur, "freeze_over_kill");
        freeze = 0;
        step(bub(1), "flush_and_hazard");
        flush = 0; hazard = 0; condition_state = 1;
        step(ld(b, 1), "load_b");

        // hazard bubble with a would-be kill carrying a store
        c = mk(32'h30, 5'b00100); vin = c; condition_state = 0; hazard = 1;
        step(bub(1), "hazard_no_kill_count");
        hazard = 0; flush = 1; condition_state = 1;
        step(bub(1), "flush_only");
        flush = 0;

        // freeze release loads the presented instruction immediately
        d = mk(32'h40, 5'b01010); vin = d;
        step(ld(d, 1), "load_d");
        e = mk(32'h50, 5'b10101); vin = e; freeze = 1;
        repeat (3) step(cur, "freeze_hold");
        freeze = 0;
        step(ld(e, 1), "freeze_release");

        // reset wins over freeze
        freeze = 1; rst = 1;
        step(bub(0), "reset_in_freeze");
        rst = 0; freeze = 0; condition_state = 0;

        // 20 consecutive kills: counter saturates at 0xF
        for (int i = 1; i <= 20; i++) begin
            vin = mk(32'h100 + 32'(i) * 32'h10, 5'b11111);
            step(kl(vin, (i > 15) ? 4'hF : 4'(i)), "saturating_kill");
        end
        f = mk(32'h400, 5'b11011); vin = f; condition_state = 1;
        step(ld(f, 15), "pass_after_saturation");
        condition_state = 0; hazard = 1;
        step(bub(15), "bubble_after_saturation");
        hazard = 0; rst = 1;
        step(bub(0), "final_reset");
        rst = 0;

        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
